// File: rtl/conv3x3_mac_sched.sv
// conv3x3_mac_sched
// Sequential 3x3 window dot product: one DW x DW multiplier and an ACC_W
// accumulator step through the nine taps, one tap per clock.
// Upstream and downstream use valid/ready handshakes. A 9-entry weight
// register file is writable only while idle, so weights are frozen per window.
//
// Optional build macro: CONV_MAC_SAT_EN
//   defined   : out_data saturates to all-ones when out_sum exceeds the DW range
//   undefined : out_data is the low DW bits of out_sum (truncation)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a window; in_ready high, weight writes accepted
// MAC   | one multiply-accumulate per clock, taps 0..8 in row-major order
// DONE  | out_valid high, result held until the out_ready handshake

module conv3x3_mac_sched #(
    parameter int DW    = 8,
    parameter int TAPS  = 9,
    parameter int ACC_W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wt_we,
    input  logic [3:0]           wt_addr,
    input  logic [DW-1:0]        wt_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TAPS*DW-1:0]   in_pix,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);

    state_t                state;
    logic [TAPS*DW-1:0]    win;
    logic [DW-1:0]         wt [TAPS];
    logic [ACC_W-1:0]      acc;
    logic [3:0]            tap;

    logic [DW-1:0]         pix_sel;
    logic [DW-1:0]         wt_sel;
    logic [2*DW-1:0]       prod;
    logic [ACC_W-1:0]      acc_next;
    logic [DW-1:0]         data_next;
    logic                  wt_wr_en;

    // Select the current tap operands, form the product and the next sum.
    always_comb begin
        pix_sel  = win[DW*tap +: DW];
        wt_sel   = wt[tap];
        prod     = {{DW{1'b0}}, pix_sel} * {{DW{1'b0}}, wt_sel};
        acc_next = acc + {{(ACC_W-2*DW){1'b0}}, prod};
`ifdef CONV_MAC_SAT_EN
        if (|acc_next[ACC_W-1:DW]) begin
            data_next = {DW{1'b1}};
        end else begin
            data_next = acc_next[DW-1:0];
        end
`else
        data_next = acc_next[DW-1:0];
`endif
    end

    // Out-of-range addresses and writes outside IDLE are silently dropped.
    always_comb begin
        wt_wr_en = wt_we && (state == IDLE) && (wt_addr <= LAST_TAP);
    end

    // Weight register file; a write on the accept edge is seen by that window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                wt[i] <= '0;
            end
        end else if (wt_wr_en) begin
            wt[wt_addr] <= wt_data;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win       <= '0;
            acc       <= '0;
            tap       <= '0;
            out_sum   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        win      <= in_pix;
                        acc      <= '0;
                        tap      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap == LAST_TAP) begin
                        tap       <= '0;
                        out_sum   <= acc_next;
                        out_data  <= data_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake edge, never alongside it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_sched.sv
// Testbench for conv3x3_mac_sched: expected results are queued when a window
// is sent and compared when the output handshake occurs.

module tb_conv3x3_mac_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wt_we = 1'b0;
    logic [3:0]  wt_addr = '0;
    logic [7:0]  wt_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] in_pix = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [19:0] out_sum;
    logic        busy;

    conv3x3_mac_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wt_we     (wt_we),
        .wt_addr   (wt_addr),
        .wt_data   (wt_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    int          n_exp    = 0;
    int          mwt [9];
    logic [27:0] sb_q [$];
    logic [27:0] sb_e;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [19:0] s);
`ifdef CONV_MAC_SAT_EN
        return (s > 20'd255) ? 8'hFF : s[7:0];
`else
        return s[7:0];
`endif
    endfunction

    // Output monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_val("out_sum", 32'(out_sum), 32'(sb_e[27:8]));
                check_val("out_data", 32'(out_data), 32'(sb_e[7:0]));
            end
            n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wt_write(input int a, input int d, input bit upd);
        wt_we   = 1'b1;
        wt_addr = a[3:0];
        wt_data = d[7:0];
        tick();
        wt_we = 1'b0;
        if (upd) mwt[a] = d;
    endtask

    task automatic send_win(input logic [71:0] pix, input bit push);
        int s;
        bit accepted;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(pix[8*i +: 8]) * mwt[i];
        if (push) begin
            sb_q.push_back({s[19:0], exp_data(s[19:0])});
            n_exp++;
        end
        in_pix   = pix;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) check_val("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && n_done < n_exp; i++) tick();
        if (n_done < n_exp) check_val("done_timeout", 32'(n_done), 32'(n_exp));
    endtask

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[8*i +: 8] = v;
        return p;
    endfunction

    initial begin
        logic [71:0] p;
        bit seen;
        for (int i = 0; i < 9; i++) mwt[i] = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_out_sum", 32'(out_sum), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // all weights 1, pixels 10, with latency and initiation checks
        for (int i = 0; i < 9; i++) wt_write(i, 1, 1'b1);
        send_win(fill(8'd10), 1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) check_val("lat_busy", 32'(busy), 32'd1);
            if (k == 8) check_val("lat_early", 32'(out_valid), 32'd0);
            if (k == 9) check_val("lat_valid", 32'(out_valid), 32'd1);
        end
        tick();
        check_val("ii_in_ready", 32'(in_ready), 32'd1);
        wait_done();

        // weights 1..9, pixels 2 then pixels equal to tap index
        for (int i = 0; i < 9; i++) wt_write(i, i + 1, 1'b1);
        send_win(fill(8'd2), 1'b1);
        wait_done();
        for (int i = 0; i < 9; i++) p[8*i +: 8] = 8'(i);
        send_win(p, 1'b1);
        wait_done();

        // full-scale window
        for (int i = 0; i < 9; i++) wt_write(i, 255, 1'b1);
        send_win(fill(8'd255), 1'b1);
        wait_done();

        // backpressure with weights 1..9 and pixels 3
        for (int i = 0; i < 9; i++) wt_write(i, i + 1, 1'b1);
        out_ready = 1'b0;
        send_win(fill(8'd3), 1'b1);
        for (int i = 0; i < 30 && !out_valid; i++) tick();
        check_val("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_pix   = {$urandom(), $urandom(), $urandom()};
            tick();
            check_val("bp_valid_hold", 32'(out_valid), 32'd1);
            check_val("bp_sum_hold", 32'(out_sum), 32'd135);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_val("bp_rel_in_ready", 32'(in_ready), 32'd1);
        check_val("bp_rel_valid", 32'(out_valid), 32'd0);
        check_val("bp_rel_busy", 32'(busy), 32'd0);
        wait_done();

        // weight writes during MAC and out of range are dropped
        p = '0;
        p[8*4 +: 8] = 8'd1;
        send_win(p, 1'b1);
        wt_write(4, 7, 1'b0);
        wait_done();
        wt_write(12, 99, 1'b0);
        send_win(fill(8'd1), 1'b1);
        wait_done();
        send_win(p, 1'b1);
        wait_done();

        // reset in the middle of a window
        send_win(fill(8'd9), 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) mwt[i] = 0;
        check_val("mrst_in_ready", 32'(in_ready), 32'd1);
        check_val("mrst_out_valid", 32'(out_valid), 32'd0);
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_out_sum", 32'(out_sum), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_val("mrst_no_valid", 32'(seen), 32'd0);
        check_val("mrst_ready_after", 32'(in_ready), 32'd1);
        send_win(fill(8'd200), 1'b1);
        wait_done();

        tick();
        check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "global timeout");
    end

endmodule
